dm_access_arbiter: RTL and testbench



---
 rtl/dm_arb_pkg.sv | 26 ++
 rtl/dm_rr_arbiter.sv | 28 ++
 rtl/dm_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types, size codes and helpers for the data-memory access arbiter
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // Size code 11 is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dm_rr_arbiter.sv
// rtl/dm_rr_arbiter.sv - two-way round-robin arbiter with a last-grant register
module dm_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_grant;

    // On contention the requester not granted last time wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (en && (|req)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// rtl/dm_access_arbiter.sv - byte-serialising arbiter for the data memory; optional DM_ARB_ALIGN_CHK_EN adds error ports
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          AW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_size,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_ack,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_size,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_ack,
    output logic [31:0]   m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
`ifdef DM_ARB_ALIGN_CHK_EN
    output logic          m0_err,
    output logic          m1_err,
`endif
    output logic          busy
);

    state_t        state, state_nx;
    logic [1:0]    req, gnt;
    logic          sel_we, sel_fault, last_byte;
    logic [1:0]    sel_size;
    logic [2:0]    sel_n;
    logic [31:0]   sel_addr, sel_wdata;

    logic          g_q, we_q, err_q;
    logic [2:0]    n_q;
    logic [1:0]    cnt_q;
    logic [AW-1:0] off_q;
    logic [31:0]   sh_q, rdata0_q, rdata1_q;
    logic [23:0]   asm_q;

    assign req = {m1_req, m0_req};

    dm_rr_arbiter u_rr (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (state == IDLE),
        .gnt (gnt)
    );

    always_comb begin
        sel_we    = gnt[1] ? m1_we    : m0_we;
        sel_size  = gnt[1] ? m1_size  : m0_size;
        sel_addr  = gnt[1] ? m1_addr  : m0_addr;
        sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
        sel_n     = size_bytes(sel_size);
    end

`ifdef DM_ARB_ALIGN_CHK_EN
    always_comb begin
        sel_fault = 1'b0;
        if ((sel_n == 3'd2) && sel_addr[0]) sel_fault = 1'b1;
        if ((sel_n == 3'd4) && (sel_addr[1:0] != 2'b00)) sel_fault = 1'b1;
        if (sel_addr < BASE_ADDR) sel_fault = 1'b1;
        if ((sel_addr - BASE_ADDR) >= (32'd1 << AW)) sel_fault = 1'b1;
    end

    assign m0_err = (state == ACK) && !g_q && err_q;
    assign m1_err = (state == ACK) &&  g_q && err_q;
`else
    assign sel_fault = 1'b0;
`endif

    assign last_byte = ({1'b0, cnt_q} == (n_q - 3'd1));
    assign busy      = (state != IDLE);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

    always_comb begin
        state_nx  = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_nx = sel_fault ? ACK : XFER;
            end
            XFER: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = off_q + {{(AW-2){1'b0}}, cnt_q};
                mem_wdata = we_q ? sh_q[31:24] : 8'h00;
                if (last_byte) state_nx = we_q ? ACK : TAIL;
            end
            TAIL: state_nx = ACK;
            ACK: begin
                m0_ack   = !g_q;
                m1_ack   = g_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            g_q      <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            n_q      <= 3'd0;
            cnt_q    <= 2'd0;
            off_q    <= '0;
            sh_q     <= 32'h0;
            asm_q    <= 24'h0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (|req) begin
                        g_q   <= gnt[1];
                        we_q  <= sel_we;
                        n_q   <= sel_n;
                        err_q <= sel_fault;
                        cnt_q <= 2'd0;
                        asm_q <= 24'h0;
                        off_q <= AW'(sel_addr - BASE_ADDR);
                        // Left-justify the store data so the MSB byte leaves first.
                        case (sel_n)
                            3'd1:    sh_q <= {sel_wdata[7:0], 24'h0};
                            3'd2:    sh_q <= {sel_wdata[15:0], 16'h0};
                            default: sh_q <= sel_wdata;
                        endcase
                    end
                end
                XFER: begin
                    cnt_q <= cnt_q + 2'd1;
                    sh_q  <= {sh_q[23:0], 8'h00};
                    // Read data lags the issue by one cycle; byte 0 arrives while byte 1 issues.
                    if (!we_q && (cnt_q != 2'd0)) asm_q <= {asm_q[15:0], mem_rdata};
                end
                TAIL: begin
                    if (g_q) rdata1_q <= {asm_q, mem_rdata};
                    else     rdata0_q <= {asm_q, mem_rdata};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb/tb_dm_access_arbiter.sv - scoreboard bench with a byte-array reference model for dm_access_arbiter
module tb_dm_access_arbiter;
    import dm_arb_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          AW   = 10;

    logic        clk = 1'b0, rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
`ifdef DM_ARB_ALIGN_CHK_EN
    logic        m0_err, m1_err;
`endif

    dm_access_arbiter #(.BASE_ADDR(BASE), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DM_ARB_ALIGN_CHK_EN
        .m0_err(m0_err), .m1_err(m1_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Device memory attached to the DUT.
    logic [7:0] ram [0:1023];
    logic       ram_init;

    function automatic logic [7:0] seed_byte(int i);
        return 8'(i * 37 + 5);
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= seed_byte(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          nbytes;
        int          lat;
        int          issue;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        we;
        int          addr;
        logic [7:0]  wdata;
    } acc_t;

    exp_t        q0[$], q1[$];
    acc_t        aq[$];
    int          ack_order[$];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] model_rdata [2];
    int          compared = 0, mismatched = 0;
    bit          acc_chk = 0;
    int          nbytes_seen = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: big-endian byte accesses at (addr - BASE) mod 1024.
    function automatic exp_t model(int m, logic we, logic [1:0] size,
                                   logic [31:0] addr, logic [31:0] wdata);
        exp_t        e;
        int          n, a;
        logic [31:0] off, r;
        bit          fault;
        n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off   = addr - BASE;
        fault = 0;
`ifdef DM_ARB_ALIGN_CHK_EN
        if ((addr % n) != 0) fault = 1;
        if (addr < BASE || off >= 1024) fault = 1;
`endif
        e.err    = fault;
        e.nbytes = fault ? 0 : n;
        e.lat    = !acc_chk ? 0 : fault ? 1 : we ? n + 1 : n + 2;
        e.issue  = cyc;
        if (!fault) begin
            r = 0;
            for (int i = 0; i < n; i++) begin
                a = int'((off + i) % 1024);
                if (we) begin
                    ref_mem[a] = 8'(wdata >> (8 * (n - 1 - i)));
                    if (acc_chk) aq.push_back('{cyc + 1 + i, 1'b1, a, ref_mem[a]});
                end else begin
                    r = (r << 8) | ref_mem[a];
                    if (acc_chk) aq.push_back('{cyc + 1 + i, 1'b0, a, 8'h00});
                end
            end
            if (!we) model_rdata[m] = r;
        end
        e.rdata = model_rdata[m];
        return e;
    endfunction

    task automatic do_req(int m, logic we, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        bit   got;
        e = model(m, we, size, addr, wdata);
        if (m == 0) begin
            q0.push_back(e);
            m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            q1.push_back(e);
            m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout m%0d: got no ack expected ack within 100 cycles", m);
        end
        @(posedge clk); #1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_ack(int m);
        exp_t e;
        ack_order.push_back(m);
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_ack m%0d: got ack expected none", m);
        end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata_m%0d", m), (m == 0) ? m0_rdata : m1_rdata, e.rdata);
`ifdef DM_ARB_ALIGN_CHK_EN
            chk($sformatf("err_m%0d", m), (m == 0) ? m0_err : m1_err, e.err);
`endif
            chk($sformatf("nbytes_m%0d", m), nbytes_seen, e.nbytes);
            if (e.lat > 0) chk($sformatf("latency_m%0d", m), cyc - e.issue, e.lat);
        end
        nbytes_seen = 0;
    endtask

    // Monitor: compares memory accesses and acks against the scoreboard queues.
    initial begin
        acc_t a;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbytes_seen = 0;
            end else begin
                if (mem_en) begin
                    nbytes_seen++;
                    if (acc_chk) begin
                        if (aq.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL extra_access: got mem_en at %0d expected none", mem_addr);
                        end else begin
                            a = aq.pop_front();
                            chk("acc_cycle", cyc, a.cyc);
                            chk("acc_we", mem_we, a.we);
                            chk("acc_addr", mem_addr, a.addr);
                            if (a.we) chk("acc_wdata", mem_wdata, a.wdata);
                        end
                    end
                end
                if (m0_ack && m1_ack) chk("dual_ack", 2'b11, 2'b00);
                if (m0_ack) check_ack(0);
                if (m1_ack) check_ack(1);
            end
        end
    end

    task automatic rand_req(int m);
        logic [1:0] size;
        int         n, off;
        size = 2'($urandom_range(0, 3));
        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off  = m * 512 + 4 * $urandom_range(0, 127) + ($urandom_range(0, 3) & ~(n - 1));
        do_req(m, 1'($urandom_range(0, 1)), size, BASE + off, $urandom);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; ram_init = 1'b1;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = seed_byte(i);
        model_rdata[0] = 0; model_rdata[1] = 0;
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {m1_ack, m0_ack}, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_rdata1", m1_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        acc_chk = 1;
        do_req(0, 1, SZ_WORD, BASE, 32'h1122_3344);
        do_req(0, 0, SZ_WORD, BASE, 0);
        chk("tp_word_load", m0_rdata, 32'h1122_3344);
        do_req(1, 1, SZ_HALF, BASE + 6, 32'h0000_BEEF);
        do_req(1, 0, SZ_BYTE, BASE + 7, 0);
        chk("tp_byte_load", m1_rdata, 32'h0000_00EF);
        do_req(0, 0, SZ_WORD, BASE + 2, 0);
        do_req(1, 1, SZ_WORD, BASE + 32'h3FE, 32'hCAFE_F00D);
        do_req(1, 0, SZ_WORD, BASE + 32'h3FE, 0);
        do_req(0, 0, SZ_BYTE, BASE - 1, 0);
        do_req(0, 0, 2'b11, BASE + 12, 0);
        do_req(1, 0, SZ_HALF, BASE + 2, 0);
        acc_chk = 0;

        // Reset during cycle 2 of a word store: two bytes land, no ack.
        m0_we = 1; m0_size = SZ_WORD; m0_addr = BASE + 32'h10; m0_wdata = 32'hAABB_CCDD; m0_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; m0_req = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_ack", m0_ack, 0);
        chk("abort_rdata0", m0_rdata, 0);
        chk("abort_rdata1", m1_rdata, 0);
        ref_mem[16] = 8'hAA; ref_mem[17] = 8'hBB;
        model_rdata[0] = 0; model_rdata[1] = 0;
        chk("abort_ram10", ram[16], 8'hAA);
        chk("abort_ram11", ram[17], 8'hBB);
        chk("abort_ram12", ram[18], ref_mem[18]);
        chk("abort_ram13", ram[19], ref_mem[19]);
        @(posedge clk); #1;

        ack_order.delete();
        fork
            do_req(0, 0, SZ_WORD, BASE + 32'h20, 0);
            do_req(1, 0, SZ_HALF, BASE + 32'h24, 0);
        join
        do_req(0, 1, SZ_BYTE, BASE + 32'h28, 32'h5A);
        fork
            do_req(0, 0, SZ_BYTE, BASE + 32'h28, 0);
            do_req(1, 1, SZ_WORD, BASE + 32'h2C, 32'h0102_0304);
        join
        chk("rr_count", ack_order.size(), 5);
        if (ack_order.size() == 5) begin
            chk("rr_order", {ack_order[0][0], ack_order[1][0], ack_order[2][0],
                             ack_order[3][0], ack_order[4][0]}, 5'b01010);
        end

        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    rand_req(0);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    rand_req(1);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
        join

        repeat (3) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_final_bad_bytes", bad, 0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
